// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared widths, defaults and stage control type for the MAC datapath
package mac_pkg;

  localparam int MAC_LANES = 16;
  localparam int MAC_DW    = 8;
  localparam int MAC_ACCW  = 24;

  typedef struct packed {
    logic valid;
    logic last;
  } stage_ctl_t;

  function automatic int tree_w(input int lanes, input int dw);
    return 2 * dw + $clog2(lanes);
  endfunction

endpackage

// File: rtl/mac_adder_tree.sv
// rtl/mac_adder_tree.sv - combinational binary reduction of LANES products to tree_w bits
module mac_adder_tree
  import mac_pkg::*;
#(
  parameter int LANES  = MAC_LANES,
  parameter int DW     = MAC_DW,
  parameter bit SIGNED = 1'b0
) (
  input  logic [LANES*2*DW-1:0]         terms_i,
  output logic [tree_w(LANES, DW)-1:0] sum_o
);

  localparam int TW   = tree_w(LANES, DW);
  localparam int PW   = 2 * DW;
  localparam int LVLS = $clog2(LANES);

  // Every level is carried at full tree width, so no partial sum can overflow.
  for (genvar l = 0; l <= LVLS; l++) begin : g_lvl
    logic [TW-1:0] v [LANES >> l];
    if (l == 0) begin : g_leaf
      for (genvar i = 0; i < LANES; i++) begin : g_ext
        logic [PW-1:0] t;
        assign t    = terms_i[i*PW +: PW];
        assign v[i] = {{(TW-PW){SIGNED & t[PW-1]}}, t};
      end
    end else begin : g_sum
      for (genvar i = 0; i < (LANES >> l); i++) begin : g_add
        assign v[i] = g_lvl[l-1].v[2*i] + g_lvl[l-1].v[2*i+1];
      end
    end
  end

  assign sum_o = g_lvl[LVLS].v[0];

endmodule

// File: rtl/mac_vec_acc.sv
// rtl/mac_vec_acc.sv - pipelined vector MAC with per-vector accumulate and stallable output
// Define MAC_SATURATE_EN for a saturating accumulator with a sticky per-vector ovf flag.
module mac_vec_acc
  import mac_pkg::*;
#(
  parameter int LANES  = MAC_LANES,
  parameter int DW     = MAC_DW,
  parameter int ACCW   = MAC_ACCW,
  parameter bit SIGNED = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [LANES*DW-1:0] p,
  input  logic [LANES*DW-1:0] w,
  input  logic                in_valid,
  input  logic                in_last,
  output logic                in_ready,
  output logic [ACCW-1:0]     s,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                ovf
);

  localparam int TW = tree_w(LANES, DW);
  localparam int PW = 2 * DW;

  logic                  adv;
  stage_ctl_t            s0_q, s1_q, s2_q;
  logic [LANES*DW-1:0]   p_q, w_q;
  logic [LANES*PW-1:0]   prod_d, prod_q;
  logic [TW-1:0]         tree_d, tree_q;
  logic [ACCW-1:0]       tree_ext, base, acc_d, acc_q, s_q;
  logic                  first_q, out_valid_q;

  assign adv       = !(out_valid_q && !out_ready);
  assign in_ready  = adv && !rst;
  assign s         = s_q;
  assign out_valid = out_valid_q;

  // Beats are registered ahead of the multipliers, giving a three-edge path to acc.
  for (genvar i = 0; i < LANES; i++) begin : g_mul
    logic [PW-1:0] pe, we;
    assign pe = {{DW{SIGNED & p_q[i*DW+DW-1]}}, p_q[i*DW +: DW]};
    assign we = {{DW{SIGNED & w_q[i*DW+DW-1]}}, w_q[i*DW +: DW]};
    assign prod_d[i*PW +: PW] = pe * we;
  end

  mac_adder_tree #(.LANES(LANES), .DW(DW), .SIGNED(SIGNED)) u_tree (
    .terms_i(prod_q),
    .sum_o  (tree_d)
  );

  if (ACCW > TW) begin : g_ext
    assign tree_ext = {{(ACCW-TW){SIGNED & tree_q[TW-1]}}, tree_q};
  end else begin : g_noext
    assign tree_ext = tree_q;
  end

  assign base = first_q ? '0 : acc_q;

`ifdef MAC_SATURATE_EN
  logic [ACCW:0] wide;
  logic          sat, ovf_acc_d, ovf_acc_q, ovf_q;

  assign wide = {SIGNED & base[ACCW-1], base} + {SIGNED & tree_ext[ACCW-1], tree_ext};

  always_comb begin
    acc_d = wide[ACCW-1:0];
    sat   = 1'b0;
    if (SIGNED) begin
      if (wide[ACCW] != wide[ACCW-1]) begin
        sat   = 1'b1;
        acc_d = wide[ACCW] ? {1'b1, {(ACCW-1){1'b0}}} : {1'b0, {(ACCW-1){1'b1}}};
      end
    end else if (wide[ACCW]) begin
      sat   = 1'b1;
      acc_d = '1;
    end
  end

  assign ovf_acc_d = (first_q ? 1'b0 : ovf_acc_q) | sat;
  assign ovf       = ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_acc_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else if (adv && s2_q.valid) begin
      ovf_acc_q <= ovf_acc_d;
      if (s2_q.last) ovf_q <= ovf_acc_d;
    end
  end
`else
  assign acc_d = base + tree_ext;
  assign ovf   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (adv) begin
      p_q    <= p;
      w_q    <= w;
      prod_q <= prod_d;
      tree_q <= tree_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_q        <= '0;
      s1_q        <= '0;
      s2_q        <= '0;
      acc_q       <= '0;
      first_q     <= 1'b1;
      s_q         <= '0;
      out_valid_q <= 1'b0;
    end else if (adv) begin
      s0_q.valid <= in_valid;
      s0_q.last  <= in_valid && in_last;
      s1_q       <= s0_q;
      s2_q       <= s1_q;
      if (s2_q.valid) begin
        acc_q   <= acc_d;
        first_q <= s2_q.last;
      end
      if (s2_q.valid && s2_q.last) begin
        s_q         <= acc_d;
        out_valid_q <= 1'b1;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mac_vec_acc.sv
// tb/tb_mac_vec_acc.sv - directed checks of mac_vec_acc on default, signed and narrow-accumulator instances
module tb_mac_vec_acc;

  localparam int LANES = 16;

`ifdef MAC_SATURATE_EN
  localparam logic [19:0] SAT_S = 20'hFFFFF;
  localparam logic        SAT_O = 1'b1;
`else
  localparam logic [19:0] SAT_S = 20'hFC020;
  localparam logic        SAT_O = 1'b0;
`endif

  typedef struct {
    logic [7:0]  pb;
    logic [7:0]  wb;
    int          nb;
    logic [23:0] e0;
    logic [23:0] e1;
    logic [19:0] e2;
    logic        o2;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst, in_valid, in_last, out_ready;
  logic [LANES*8-1:0]  p, w;
  logic [23:0]         s0, s1;
  logic [19:0]         s2;
  logic                ov0, ov1, ov2, of0, of1, of2, ir0, ir1, ir2, ir_all;
  int                  n_err = 0;
  int                  n_chk = 0;
  vec_t                tbl [8];

  assign ir_all = ir0 & ir1 & ir2;

  mac_vec_acc u_d0 (
    .clk(clk), .rst(rst), .p(p), .w(w), .in_valid(in_valid), .in_last(in_last),
    .in_ready(ir0), .s(s0), .out_valid(ov0), .out_ready(out_ready), .ovf(of0)
  );

  mac_vec_acc #(.SIGNED(1'b1)) u_d1 (
    .clk(clk), .rst(rst), .p(p), .w(w), .in_valid(in_valid), .in_last(in_last),
    .in_ready(ir1), .s(s1), .out_valid(ov1), .out_ready(out_ready), .ovf(of1)
  );

  mac_vec_acc #(.ACCW(20)) u_d2 (
    .clk(clk), .rst(rst), .p(p), .w(w), .in_valid(in_valid), .in_last(in_last),
    .in_ready(ir2), .s(s2), .out_valid(ov2), .out_ready(out_ready), .ovf(of2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sends nb back-to-back beats and returns the edges from the last acceptance to out_valid.
  task automatic run_vec(input logic [7:0] pb, input logic [7:0] wb, input int nb, output int lat);
    for (int b = 0; b < nb; b++) begin
      p        = {LANES{pb}};
      w        = {LANES{wb}};
      in_valid = 1'b1;
      in_last  = (b == nb - 1);
      check("in_ready before beat", ir_all, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    lat = 0;
    while (!ov0 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int    lat;
    int    n_out;
    logic [23:0] last_s;

    tbl[0] = '{8'h01, 8'h01, 1, 24'h000010, 24'h000010, 20'h00010, 1'b0};
    tbl[1] = '{8'hFF, 8'hFF, 1, 24'h0FE010, 24'h000010, 20'hFE010, 1'b0};
    tbl[2] = '{8'h80, 8'h80, 1, 24'h040000, 24'h040000, 20'h40000, 1'b0};
    tbl[3] = '{8'hFF, 8'h02, 1, 24'h001FE0, 24'hFFFFE0, 20'h01FE0, 1'b0};
    tbl[4] = '{8'h02, 8'h03, 3, 24'h000120, 24'h000120, 20'h00120, 1'b0};
    tbl[5] = '{8'h01, 8'h01, 1, 24'h000010, 24'h000010, 20'h00010, 1'b0};
    tbl[6] = '{8'hFF, 8'hFF, 2, 24'h1FC020, 24'h000020, SAT_S,     SAT_O};
    tbl[7] = '{8'h01, 8'h01, 1, 24'h000010, 24'h000010, 20'h00010, 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    p = '0; w = '0;
    repeat (3) @(posedge clk);
    #1;
    check("in_ready during reset", ir_all, 0);
    rst = 1'b0;
    #1;
    check("reset out_valid", ov0 | ov1 | ov2, 0);
    check("reset s", s0, 0);
    check("reset ovf", of0 | of1 | of2, 0);
    check("reset in_ready", ir_all, 1);

    for (int i = 0; i < 8; i++) begin
      run_vec(tbl[i].pb, tbl[i].wb, tbl[i].nb, lat);
      check($sformatf("vec%0d latency", i), lat, 3);
      check($sformatf("vec%0d valid all", i), ov0 & ov1 & ov2, 1);
      check($sformatf("vec%0d s unsigned", i), s0, tbl[i].e0);
      check($sformatf("vec%0d s signed", i), s1, tbl[i].e1);
      check($sformatf("vec%0d s accw20", i), s2, tbl[i].e2);
      check($sformatf("vec%0d ovf unsigned", i), of0, 0);
      check($sformatf("vec%0d ovf signed", i), of1, 0);
      check($sformatf("vec%0d ovf accw20", i), of2, tbl[i].o2);
      @(posedge clk); #1;
      check($sformatf("vec%0d consumed", i), ov0 | ov1 | ov2, 0);
    end

    // Backpressure: output held, one upstream beat waiting on the inputs.
    out_ready = 1'b0;
    run_vec(8'h01, 8'h01, 1, lat);
    check("bp first latency", lat, 3);
    p = {LANES{8'h02}}; w = {LANES{8'h02}}; in_valid = 1'b1; in_last = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("bp s held", s0, 24'h000010);
      check("bp in_ready low", ir_all, 0);
      check("bp out_valid held", ov0 & ov1 & ov2, 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    n_out = 0; last_s = '0;
    for (int c = 0; c < 10; c++) begin
      if (ov0) begin
        n_out++;
        last_s = s0;
      end
      @(posedge clk); #1;
    end
    check("bp outputs after release", n_out, 1);
    check("bp held beat sum", last_s, 24'h000040);

    // Reset in the middle of a four-beat vector.
    p = {LANES{8'h05}}; w = {LANES{8'h05}}; in_valid = 1'b1; in_last = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mid rst in_ready", ir_all, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      check("post rst out_valid", ov0 | ov1 | ov2, 0);
      @(posedge clk); #1;
    end
    run_vec(8'h01, 8'h01, 1, lat);
    check("post rst latency", lat, 3);
    check("post rst s unsigned", s0, 24'h000010);
    check("post rst s signed", s1, 24'h000010);
    check("post rst s accw20", s2, 20'h00010);
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mac_vec_acc.md
# mac_vec_acc

Parametrised, pipelined vector multiply-accumulate unit for the neuron datapath and the generalised successor to the fixed 16-lane `mac1`. Each accepted beat carries `LANES` packed pixel/weight pairs. The block multiplies them lane-wise, reduces the products through an adder tree, and accumulates across a multi-beat vector. It emits one sum per vector through a valid/ready handshake, so downstream activation logic can stall it.

## Interface
Parameters:
- `LANES`, 16: lanes per beat; power of two, ≥2.
- `DW`, 8: bits per pixel and per weight element.
- `ACCW`, 24: accumulator/output width; must be ≥ `2*DW+$clog2(LANES)`.
- `SIGNED`, 0: 1 treats `p`/`w` elements and all sums as two's complement; 0 treats them as unsigned.

Ports:
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `p`, in, `LANES*DW`: pixels; lane i at `[i*DW +: DW]`.
- `w`, in, `LANES*DW`: weights, same packing as `p`.
- `in_valid`, in, 1: beat present on `p`/`w`/`in_last`.
- `in_last`, in, 1: beat is the final beat of the current vector.
- `in_ready`, out, 1: block can accept a beat this cycle.
- `s`, out, `ACCW`: vector sum.
- `out_valid`, out, 1: `s` is valid.
- `out_ready`, in, 1: consumer takes `s`.
- `ovf`, out, 1: sticky-per-vector overflow flag, qualified by `out_valid`.

## Operation
- Beat accepted on an edge where `in_valid && in_ready`.
- Stage 1 (S1) registers the `LANES` products, each `2*DW` bits, sign- or zero-extended per `SIGNED`, plus a valid bit and a last bit.
- Stage 2 (S2) registers the tree sum, width `TW = 2*DW+$clog2(LANES)`, which is exact with no overflow possible.
- Stage 3 (S3), the accumulator:
  - `acc <= (first ? 0 : acc) + ext(tree)`, with `ext` extending to `ACCW` bits.
  - `first` is set by reset and after every last beat, and cleared by any non-last beat.
  - On a last beat, `s` loads the new `acc`, `out_valid` is set, and `ovf` loads the accumulated overflow for the vector.
- Global stall: `adv = !(out_valid && !out_ready)`, `in_ready = adv`. When `adv = 0`, every stage register, `acc`, and `first` hold.
- `out_valid` clears on an edge where `out_ready` is high, unless a new last beat reaches S3 on the same edge. In that case `s` and `ovf` reload and `out_valid` stays high.
- Bubbles: the valid bits of S1 and S2 gate all updates. An invalid stage never changes `acc` or `first`.
- Single-beat vectors (`in_last` on the first beat) are legal.

## Timing
- Reset values: `in_ready`=1 after the reset edge (0 while `rst` is high), `out_valid`=0, `s`=0, `ovf`=0, `acc`=0, `first`=1, stage valid bits 0.
- Latency: a last beat accepted at edge E0 gives `out_valid` high after edge E0+3 when there are no stalls. A non-last beat reaches `acc` at E0+3.
- Throughput: one beat per cycle while `out_ready` is high or `out_valid` is low.
- When `out_valid && !out_ready`, `s`, `ovf`, `out_valid` and all pipeline contents are held unchanged, and no beat is lost or duplicated.
- `rst` mid-vector: all partial sums and in-flight beats are discarded. The next accepted beat starts a new vector.
- `in_last` without `in_valid` is ignored.

## Configuration
- Macro `MAC_SATURATE_EN`.
- Defined:
  - The S3 add saturates to the `ACCW` range: unsigned `[0, 2^ACCW-1]`, signed `[-2^(ACCW-1), 2^(ACCW-1)-1]`.
  - A saturated vector keeps its clamped value for the remaining beats, still adding subsequent contributions to the clamped value with re-saturation.
  - `ovf` is set if any beat of the vector saturated.
- Undefined: `acc` wraps modulo `2^ACCW`, and `ovf` is a constant 0.

## Structure
- Shared package `mac_pkg`:
  - function `tree_w(LANES, DW)` returning `TW`;
  - localparam defaults `MAC_LANES`, `MAC_DW`, `MAC_ACCW`;
  - a typedef for the per-stage valid/last control struct.
- One sub-module, `mac_adder_tree`: a combinational parametrised reduction of `LANES` `2*DW`-bit terms to `TW` bits, with sign handling per `SIGNED`. The S2 register lives in `mac_vec_acc`.

## Test plan
- Defaults (`LANES`=16, `DW`=8, `ACCW`=24, `SIGNED`=0); every byte of `p` and `w` = 0x01, single beat with `in_last` → `out_valid` 3 cycles after acceptance, `s`=0x000010, `ovf`=0.
- All bytes 0xFF, single beat → `s`=0x0FE010. With `SIGNED`=1 and all bytes 0x80 → `s`=0x040000. With `SIGNED`=1, `p` bytes 0xFF (−1) and `w` bytes 0x02 → `s`=0xFFFFE0 (−32).
- Three back-to-back beats, all `p`=0x02 and `w`=0x03, last on beat 3, followed by a single-beat vector of 0x01s → `s`=0x000120 and then `s`=0x000010. The second sum confirms `acc` restarted from 0.
- Backpressure: `out_ready` low for 5 cycles while `out_valid` is high → `s` stable, `in_ready`=0, an upstream beat held on the inputs is accepted exactly once after `out_ready` rises.
- `ACCW`=20, two beats of all 0xFF: with `MAC_SATURATE_EN` → `s`=0xFFFFF, `ovf`=1; without it → `s`=0xFC020, `ovf`=0.
- Assert `rst` for 1 cycle after 2 beats of a 4-beat vector, then send a single beat of 0x01s → `out_valid` stays low through reset, then `s`=0x000010.
